input_conditioner: RTL and testbench
====================================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, number of consecutive clock cycles a synchronised input must differ from its debounced value before the change is committed; legal range >= 1.
REQ-002 Port clock  input  1  system clock; all state updates on its rising edge.
REQ-003 Port reset  input  1  reset, asynchronous, active-high.
REQ-004 Port fertilise_button  input  1  raw pushbutton, active-low (0 = pressed), asynchronous to clock.
REQ-005 Port reset_button  input  1  raw pushbutton, active-low (0 = pressed), asynchronous to clock.
REQ-006 Port splinker_switch  input  1  raw slide switch, active-high, asynchronous to clock.
REQ-007 Port dripper_switch  input  1  raw slide switch, active-high, asynchronous to clock.
REQ-008 Port fertilise_push  output  1  one-cycle pulse on each committed press of fertilise_button.
REQ-009 Port reset_request  output  1  level, high while reset_button is committed as pressed.
REQ-010 Port splinker_level  output  1  debounced splinker_switch.
REQ-011 Port dripper_level  output  1  debounced dripper_switch.
REQ-012 Port switch_changed  output  1  one-cycle pulse when either debounced switch level commits a change.

Function
REQ-013 Each of the four raw inputs SHALL pass through its own two-flop synchroniser; only the second-stage output (sync_out) SHALL feed later logic.
REQ-014 Each channel SHALL hold a debounced value (stable) and a cycle counter sized to hold DEBOUNCE_CYCLES-1 without wrap.
REQ-015 On each edge where sync_out == stable, the channel counter SHALL load 0 and stable SHALL hold.
REQ-016 On each edge where sync_out != stable and counter < DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-017 On an edge where sync_out != stable and counter == DEBOUNCE_CYCLES-1, stable SHALL load sync_out and the counter SHALL load 0 (commit).
REQ-018 Latency: a raw change first sampled at edge k with no further toggling SHALL commit at edge k+1+DEBOUNCE_CYCLES.
REQ-019 Any bounce returning sync_out to stable before commit SHALL restart the count from 0; no partial credit is kept.
REQ-020 fertilise_push SHALL be registered high for exactly the one cycle after a commit of the fertilise stable value from 1 to 0; a release commit (0 to 1) SHALL NOT pulse.
REQ-021 A held press SHALL produce exactly one fertilise_push; there SHALL be no auto-repeat.
REQ-022 reset_request SHALL equal the inverse of the reset_button stable value.
REQ-023 splinker_level and dripper_level SHALL equal their channel stable values.
REQ-024 switch_changed SHALL be registered high for the one cycle after any edge committing either switch channel; simultaneous commits of both SHALL produce one single-cycle pulse.
REQ-025 Channels SHALL be fully independent: activity on one channel SHALL NOT alter any other channel's counter or stable value.
REQ-026 Both switches high is a legal output state and SHALL be passed through unfiltered; error handling lies downstream.

Reset
REQ-027 While reset is high, the button synchroniser flops and button stable values SHALL be 1, and the switch synchroniser flops and switch stable values SHALL be 0.
REQ-028 While reset is high, all counters SHALL be 0 and fertilise_push, reset_request, splinker_level, dripper_level and switch_changed SHALL be 0.
REQ-029 Reset asserted mid-count SHALL discard the count without a commit or pulse.
REQ-030 After reset deasserts, a switch already high SHALL appear on its level output only after the full REQ-018 latency, with one switch_changed pulse.

Verification (DEBOUNCE_CYCLES = 4)
REQ-031 Fertilise press: drive fertilise_button low at edge 10 and hold for 20 cycles -> fertilise_push high only in the cycle after edge 15; no further pulse during the hold or on release.
REQ-032 Bounce: drive fertilise_button low for 3 cycles, high for 1, then low for 10 -> exactly one fertilise_push, committed 5 edges after the final low transition.
REQ-033 Switches: raise splinker_switch and dripper_switch at the same edge -> both level outputs rise at the same edge and switch_changed pulses once; lowering only dripper_switch -> dripper_level falls and switch_changed pulses once.
REQ-034 Reset button: hold reset_button low for 8 cycles, then high -> reset_request high from 5 edges after the press until 5 edges after the release.
REQ-035 Reset mid-count: press fertilise_button, assert reset 2 cycles later for 1 cycle, keep the button low -> no pulse during reset, then one pulse 5 edges after the button is first sampled low following reset release.
REQ-036 Power-up: hold splinker_switch high through reset -> splinker_level is 0 during reset and rises 5 edges after the first post-reset edge, with one switch_changed pulse.

Source files
------------

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - synchronise and debounce two pushbuttons and two slide switches
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic fertilise_button,
    input  logic reset_button,
    input  logic splinker_switch,
    input  logic dripper_switch,
    output logic fertilise_push,
    output logic reset_request,
    output logic splinker_level,
    output logic dripper_level,
    output logic switch_changed
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    // Channel order: 0 fertilise, 1 reset button, 2 splinker, 3 dripper.
    // Buttons idle high (released), switches idle low.
    localparam logic [3:0] IDLE = 4'b0011;

    logic [3:0]    raw;
    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [3:0]    stable;
    logic [3:0]    commit;
    logic [CW-1:0] cnt [4];

    assign raw = {dripper_switch, splinker_switch, reset_button, fertilise_button};

    always_comb begin
        commit = '0;
        for (int i = 0; i < 4; i++) begin
            commit[i] = (sync2[i] != stable[i]) && (cnt[i] == LAST);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1          <= IDLE;
            sync2          <= IDLE;
            stable         <= IDLE;
            fertilise_push <= 1'b0;
            switch_changed <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (commit[i]) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
            // Only the press direction (1 -> 0) of the fertilise button pulses.
            fertilise_push <= commit[0] && !sync2[0];
            switch_changed <= commit[2] || commit[3];
        end
    end

    assign reset_request  = ~stable[1];
    assign splinker_level = stable[2];
    assign dripper_level  = stable[3];

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - randomized and directed bench for input_conditioner
module tb_input_conditioner;

    localparam int D = 4;
    localparam logic [3:0] IDLE = 4'b0011;

    logic clock;
    logic reset;
    logic fertilise_button;
    logic reset_button;
    logic splinker_switch;
    logic dripper_switch;
    logic fertilise_push;
    logic reset_request;
    logic splinker_level;
    logic dripper_level;
    logic switch_changed;

    input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clock           (clock),
        .reset           (reset),
        .fertilise_button(fertilise_button),
        .reset_button    (reset_button),
        .splinker_switch (splinker_switch),
        .dripper_switch  (dripper_switch),
        .fertilise_push  (fertilise_push),
        .reset_request   (reset_request),
        .splinker_level  (splinker_level),
        .dripper_level   (dripper_level),
        .switch_changed  (switch_changed)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_push, push_edge, n_chg, chg_edge;

    // Reference: a change commits once D consecutive two-edge-delayed samples all differ from the held value.
    bit m_h1 [4];
    bit m_h2 [4];
    bit m_st [4];
    bit m_win [4][$];
    bit m_push;
    bit m_chg;

    always @(posedge clock or posedge reset) begin : model
        bit c [4];
        bit use_s;
        bit all_diff;
        bit [3:0] r;
        if (reset) begin
            for (int ch = 0; ch < 4; ch++) begin
                m_h1[ch] = IDLE[ch];
                m_h2[ch] = IDLE[ch];
                m_st[ch] = IDLE[ch];
                m_win[ch].delete();
            end
            m_push = 1'b0;
            m_chg  = 1'b0;
        end else begin
            r = {dripper_switch, splinker_switch, reset_button, fertilise_button};
            for (int ch = 0; ch < 4; ch++) begin
                use_s = m_h2[ch];
                m_h2[ch] = m_h1[ch];
                m_h1[ch] = r[ch];
                m_win[ch].push_back(use_s);
                if (m_win[ch].size() > D) void'(m_win[ch].pop_front());
                c[ch] = 1'b0;
                if (m_win[ch].size() == D) begin
                    all_diff = 1'b1;
                    foreach (m_win[ch][j]) if (m_win[ch][j] == m_st[ch]) all_diff = 1'b0;
                    if (all_diff) begin
                        c[ch] = 1'b1;
                        m_st[ch] = use_s;
                        m_win[ch].delete();
                    end
                end
            end
            m_push = c[0] && !m_st[0];
            m_chg  = c[2] || c[3];
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        logic [4:0] act, exp;
        @(negedge clock);
        cyc++;
        act = {fertilise_push, reset_request, splinker_level, dripper_level, switch_changed};
        exp = {m_push, ~m_st[1], m_st[2], m_st[3], m_chg};
        check("outputs_vs_model", int'(act), int'(exp));
        if (fertilise_push) begin n_push++; push_edge = cyc; end
        if (switch_changed) begin n_chg++; chg_edge = cyc; end
    endtask

    task automatic clear_events();
        n_push = 0; push_edge = -1; n_chg = 0; chg_edge = -1;
    endtask

    initial begin : stim
        int k, k2, sp_rise, dr_rise, dr_fall, rr_rise, rr_fall;
        reset = 1'b1;
        fertilise_button = 1'b1;
        reset_button     = 1'b1;
        splinker_switch  = 1'b0;
        dripper_switch   = 1'b0;
        clear_events();
        repeat (3) step();
        check("reset_outputs", int'({fertilise_push, reset_request, splinker_level, dripper_level, switch_changed}), 0);
        reset = 1'b0;
        repeat (8) step();

        // Single press held 20 cycles
        clear_events();
        fertilise_button = 1'b0; k = cyc + 1;
        repeat (20) step();
        fertilise_button = 1'b1;
        repeat (12) step();
        check("press_count", n_push, 1);
        check("press_edge", push_edge, k + 5);

        // Bounce: 3 low, 1 high, then 10 low
        clear_events();
        fertilise_button = 1'b0;
        repeat (3) step();
        fertilise_button = 1'b1;
        step();
        fertilise_button = 1'b0; k = cyc + 1;
        repeat (10) step();
        fertilise_button = 1'b1;
        repeat (12) step();
        check("bounce_count", n_push, 1);
        check("bounce_edge", push_edge, k + 5);

        // Both switches together, then dripper alone
        clear_events();
        splinker_switch = 1'b1; dripper_switch = 1'b1; k = cyc + 1;
        sp_rise = -1; dr_rise = -1;
        repeat (12) begin
            step();
            if (splinker_level && sp_rise < 0) sp_rise = cyc;
            if (dripper_level && dr_rise < 0) dr_rise = cyc;
        end
        check("splinker_rise", sp_rise, k + 5);
        check("dripper_rise", dr_rise, k + 5);
        check("both_changed_count", n_chg, 1);
        check("both_changed_edge", chg_edge, k + 5);
        clear_events();
        dripper_switch = 1'b0; k = cyc + 1; dr_fall = -1;
        repeat (12) begin
            step();
            if (!dripper_level && dr_fall < 0) dr_fall = cyc;
        end
        check("dripper_fall", dr_fall, k + 5);
        check("splinker_kept", int'(splinker_level), 1);
        check("dripper_changed_count", n_chg, 1);

        // Reset button held 8 cycles
        reset_button = 1'b0; k = cyc + 1; rr_rise = -1; rr_fall = -1;
        repeat (8) begin
            step();
            if (reset_request && rr_rise < 0) rr_rise = cyc;
        end
        reset_button = 1'b1; k2 = cyc + 1;
        repeat (12) begin
            step();
            if (reset_request && rr_rise < 0) rr_rise = cyc;
            if (!reset_request && rr_rise >= 0 && rr_fall < 0) rr_fall = cyc;
        end
        check("reset_req_rise", rr_rise, k + 5);
        check("reset_req_fall", rr_fall, k2 + 5);

        // Reset mid-count with the button held down
        clear_events();
        fertilise_button = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        step();
        check("midcount_no_pulse", n_push, 0);
        reset = 1'b0; k = cyc + 1;
        repeat (12) step();
        check("midcount_count", n_push, 1);
        check("midcount_edge", push_edge, k + 5);
        fertilise_button = 1'b1;
        repeat (12) step();

        // Power-up with splinker already high
        splinker_switch = 1'b1; dripper_switch = 1'b0;
        reset = 1'b1;
        repeat (3) step();
        check("powerup_level_in_reset", int'(splinker_level), 0);
        reset = 1'b0; k = cyc + 1; sp_rise = -1;
        clear_events();
        repeat (12) begin
            step();
            if (splinker_level && sp_rise < 0) sp_rise = cyc;
        end
        check("powerup_rise", sp_rise, k + 5);
        check("powerup_changed_count", n_chg, 1);

        // Random phase against the model
        repeat (3000) begin
            if ($urandom_range(0, 7) == 0) fertilise_button = ~fertilise_button;
            if ($urandom_range(0, 7) == 0) reset_button     = ~reset_button;
            if ($urandom_range(0, 7) == 0) splinker_switch  = ~splinker_switch;
            if ($urandom_range(0, 7) == 0) dripper_switch   = ~dripper_switch;
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
